mdu_iterative: RTL and testbench
================================

Name: mdu_iterative

Overview:
Multi-cycle MIPS multiply/divide unit that owns the HI/LO registers and feeds them to the execute-stage ALU for mfhi/mflo. It replaces single-cycle "*" and "/" with a radix-2 shift-add multiplier and a restoring divider. Issue logic uses busy as a handshake to stall dependent mfhi/mflo and new mult/div ops.

Parameters:
WIDTH, 32, operand width; HI and LO are WIDTH bits each.
CNT_W, 6, width of the iteration counter; must satisfy 2^CNT_W > WIDTH.

Ports:
CLK  input  1  rising-edge clock
RESET  input  1  asynchronous, active-high reset
start  input  1  one-cycle request to begin the operation selected by op
op  input  2  00 mult, 01 multu, 10 div, 11 divu
A  input  WIDTH  rs operand (multiplicand / dividend)
B  input  WIDTH  rt operand (multiplier / divisor)
mthi  input  1  write A into HI
mtlo  input  1  write A into LO
busy  output  1  operation in progress
done  output  1  one-cycle pulse when HI/LO are updated or a divide is rejected
div_zero  output  1  asserted together with done when a divide was rejected for B==0
HI  output  WIDTH  HI register
LO  output  WIDTH  LO register

Behaviour:
- Reset (asynchronous): HI=0, LO=0, busy=0, done=0, div_zero=0, state=IDLE, counter=0, internal accumulators=0. Reset mid-operation discards the operation; no done pulse follows.
- States: IDLE, CALC, FIX.
- IDLE with start=1 at edge E0, operands sampled at E0:
  - For mult/div, convert A and B to magnitudes and record sign_q=A[31]^B[31] and sign_r=A[31].
  - For multu/divu, use A and B as unsigned with both sign flags 0.
  - Load counter=WIDTH and go to CALC. busy=1 from E0.
- Divide by zero (div/divu with B==0 at E0):
  - Stay in IDLE with busy=0.
  - done=1 and div_zero=1 for the single cycle after E0.
  - HI and LO are unchanged.
- CALC, one iteration per edge, WIDTH edges (E1..E32):
  - Multiply: product accumulator {P_hi,P_lo}. If P_lo[0], add multiplicand to P_hi with carry; then shift the 65-bit {carry,P_hi,P_lo} right by 1.
  - Divide (restoring): shift {R,Q} left by 1 and compute trial=R-divisor. If trial is non-negative, R=trial and Q[0]=1.
  - Decrement counter; at counter==1 go to FIX.
- FIX, edge E33:
  - Multiply: if sign_q, negate the 64-bit product; then HI=upper word, LO=lower word.
  - Divide: LO=sign_q ? -Q : Q and HI=sign_r ? -R : R. The quotient truncates toward zero; the remainder takes the sign of the dividend.
  - done=1 for the cycle after E33 with div_zero=0. busy=0 after E33; state returns to IDLE.
- Total: busy is high for 33 cycles; the result is visible on HI/LO in the cycle after E33.
- start while busy is ignored: no queueing, and the current operation is unaffected.
- mthi/mtlo in IDLE write A to HI/LO at the edge. They are ignored while busy.
- mthi and mtlo asserted together write both.
- start and mthi/mtlo asserted in the same IDLE cycle: start wins, and the write is dropped.
- start is accepted in the same cycle that done is high, since the state is already IDLE.
- Signed overflow case 0x80000000 / 0xFFFFFFFF (div) gives LO=0x80000000 and HI=0 with no exception. This falls out of magnitude arithmetic on 32-bit wrap.
- HI/LO change only in FIX, on mthi/mtlo, or on reset.

Test Plan:
1. multu A=0xFFFFFFFF, B=0xFFFFFFFF -> busy high 33 cycles, then HI=0xFFFFFFFE, LO=0x00000001, one-cycle done.
2. mult A=0xFFFFFFFD (-3), B=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. Then divu A=100, B=7 -> LO=14, HI=2.
3. div A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. div A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
4. mthi A=0x1234 then div A=5, B=0 -> next cycle done=1 and div_zero=1, busy stays 0, HI=0x1234 unchanged.
5. Start mult 6*7. At cycle 10 assert start (divu 9/3) and mtlo A=0xDEAD -> both ignored, final HI=0, LO=42.
6. Start divu 1000/10, assert RESET at cycle 15 -> HI=LO=0, busy=0 immediately, no done. After release, multu 3*4 -> LO=12.

Source files
------------

// File: rtl/mdu_iterative.sv
// Iterative MIPS multiply/divide unit owning HI/LO: radix-2 shift-add multiplier
// and restoring divider, one iteration per clock, with sign fix-up in a final cycle.
module mdu_iterative #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               sign_q_q, sign_q_d;
    logic               sign_r_q, sign_r_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               div_zero_q, div_zero_d;

    logic               is_signed;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     r_sh;
    logic [WIDTH:0]     r_sub;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;

    // Operand magnitudes and single-iteration datapath for both operations
    always_comb begin
        is_signed = ~op[0];
        mag_a     = (is_signed && A[WIDTH-1]) ? -A : A;
        mag_b     = (is_signed && B[WIDTH-1]) ? -B : B;
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        r_sh      = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_ge    = (r_sh >= {1'b0, mcand_q});
        r_sub     = r_sh - {1'b0, mcand_q};
        prod      = {acc_hi_q, acc_lo_q};
        prod_fix  = sign_q_q ? -prod : prod;
    end

    // Next-state and output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        sign_q_d   = sign_q_q;
        sign_r_d   = sign_r_q;
        mcand_d    = mcand_q;
        acc_hi_d   = acc_hi_q;
        acc_lo_d   = acc_lo_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (op[1] && (B == '0)) begin
                        done_d     = 1'b1;
                        div_zero_d = 1'b1;
                    end else begin
                        state_d  = CALC;
                        busy_d   = 1'b1;
                        cnt_d    = CNT_W'(WIDTH);
                        is_div_d = op[1];
                        sign_q_d = is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                        sign_r_d = is_signed & A[WIDTH-1];
                        acc_hi_d = '0;
                        // Divider keeps divisor in mcand and dividend in the low word;
                        // multiplier keeps multiplicand in mcand and multiplier low.
                        mcand_d  = op[1] ? mag_b : mag_a;
                        acc_lo_d = op[1] ? mag_a : mag_b;
                    end
                end else begin
                    if (mthi) hi_d = A;
                    if (mtlo) lo_d = A;
                end
            end
            CALC: begin
                if (is_div_q) begin
                    acc_hi_d = div_ge ? r_sub[WIDTH-1:0] : r_sh[WIDTH-1:0];
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
                end else begin
                    acc_hi_d = mul_sum[WIDTH:1];
                    acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = FIX;
            end
            FIX: begin
                if (is_div_q) begin
                    lo_d = sign_q_q ? -acc_lo_q : acc_lo_q;
                    hi_d = sign_r_q ? -acc_hi_q : acc_hi_q;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            sign_q_q   <= 1'b0;
            sign_r_q   <= 1'b0;
            mcand_q    <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            sign_q_q   <= sign_q_d;
            sign_r_q   <= sign_r_d;
            mcand_q    <= mcand_d;
            acc_hi_q   <= acc_hi_d;
            acc_lo_q   <= acc_lo_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign HI       = hi_q;
    assign LO       = lo_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed bench for mdu_iterative: vector table of complete operations plus
// hand-written sequences for divide-by-zero, ignored requests and mid-op reset.
module tb_mdu_iterative;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        CLK;
    logic        RESET;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[12];

    mdu_iterative #(.WIDTH(32), .CNT_W(6)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .start    (start),
        .op       (op),
        .A        (A),
        .B        (B),
        .mthi     (mthi),
        .mtlo     (mtlo),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .HI       (HI),
        .LO       (LO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; drives one start pulse and returns at the negedge after E0
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        @(negedge CLK);
        start = 1'b0;
    endtask

    // Counts busy cycles (starting from pre) and checks the completion cycle
    task automatic wait_done(input string name, input int pre,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        n = pre;
        while (busy && n < 200) begin
            n++;
            @(negedge CLK);
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: busy still high after %0d cycles", name, n);
        end
        check({name, " busy_cycles"}, 64'(n), 64'd33);
        check({name, " done"}, 64'(done), 64'd1);
        check({name, " div_zero"}, 64'(div_zero), 64'd0);
        check({name, " HI"}, 64'(HI), 64'(exp_hi));
        check({name, " LO"}, 64'(LO), 64'(exp_lo));
    endtask

    initial begin
        int  n;
        logic saw_done;
        logic [31:0] lo_before;

        vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
        vecs[3]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5]  = '{OP_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
        vecs[6]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[7]  = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
        vecs[8]  = '{OP_DIVU,  32'd5,        32'd10,       32'd5,        32'd0};
        vecs[9]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[10] = '{OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
        vecs[11] = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};

        RESET = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        A     = '0;
        B     = '0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        #1;
        check("reset HI", 64'(HI), 64'd0);
        check("reset LO", 64'(LO), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset div_zero", 64'(div_zero), 64'd0);
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);

        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done($sformatf("vec%0d", i), 0, vecs[i].exp_hi, vecs[i].exp_lo);
            @(negedge CLK);
            check($sformatf("vec%0d done_pulse_width", i), 64'(done), 64'd0);
        end

        // Back-to-back: new start accepted during the done cycle
        issue(OP_MULTU, 32'd3, 32'd5);
        wait_done("b2b_first", 0, 32'd0, 32'd15);
        issue(OP_DIVU, 32'd100, 32'd7);
        wait_done("b2b_second", 0, 32'd2, 32'd14);
        @(negedge CLK);

        // mthi then divide by zero: rejected, HI/LO untouched
        mthi = 1'b1;
        A    = 32'h1234;
        @(negedge CLK);
        mthi = 1'b0;
        check("mthi HI", 64'(HI), 64'h1234);
        lo_before = LO;
        issue(OP_DIV, 32'd5, 32'd0);
        check("divzero done", 64'(done), 64'd1);
        check("divzero div_zero", 64'(div_zero), 64'd1);
        check("divzero busy", 64'(busy), 64'd0);
        check("divzero HI", 64'(HI), 64'h1234);
        check("divzero LO", 64'(LO), 64'(lo_before));
        @(negedge CLK);
        check("divzero done_clear", 64'(done), 64'd0);
        check("divzero flag_clear", 64'(div_zero), 64'd0);

        // mthi and mtlo together write both
        mthi = 1'b1;
        mtlo = 1'b1;
        A    = 32'hCAFE;
        @(negedge CLK);
        mthi = 1'b0;
        mtlo = 1'b0;
        check("mthilo HI", 64'(HI), 64'hCAFE);
        check("mthilo LO", 64'(LO), 64'hCAFE);

        // start and mthi in the same cycle: start wins, write dropped
        mthi = 1'b1;
        issue(OP_MULTU, 32'd2, 32'd3);
        mthi = 1'b0;
        check("start_vs_mthi HI", 64'(HI), 64'hCAFE);
        wait_done("start_vs_mthi", 0, 32'd0, 32'd6);
        @(negedge CLK);

        // Requests while busy are ignored
        issue(OP_MULT, 32'd6, 32'd7);
        n = 0;
        repeat (9) begin
            if (busy) n++;
            @(negedge CLK);
        end
        start = 1'b1;
        op    = OP_DIVU;
        A     = 32'd9;
        B     = 32'd3;
        if (busy) n++;
        @(negedge CLK);
        start = 1'b0;
        mtlo  = 1'b1;
        A     = 32'hDEAD;
        if (busy) n++;
        @(negedge CLK);
        mtlo  = 1'b0;
        check("ignore_busy LO_mid", 64'(LO), 64'd6);
        wait_done("ignore_busy", n, 32'd0, 32'd42);
        @(negedge CLK);
        check("ignore_busy no_second_op", 64'(busy), 64'd0);

        // Reset mid-operation discards it without a done pulse
        issue(OP_DIVU, 32'd1000, 32'd10);
        repeat (14) @(negedge CLK);
        #2;
        RESET = 1'b1;
        #1;
        check("midreset HI", 64'(HI), 64'd0);
        check("midreset LO", 64'(LO), 64'd0);
        check("midreset busy", 64'(busy), 64'd0);
        check("midreset done", 64'(done), 64'd0);
        @(negedge CLK);
        RESET = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge CLK);
            if (done) saw_done = 1'b1;
        end
        check("midreset no_done", 64'(saw_done), 64'd0);
        issue(OP_MULTU, 32'd3, 32'd4);
        wait_done("after_reset", 0, 32'd0, 32'd12);
        @(negedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
